// File: rtl/writeback_sequencer.sv
// -----------------------------------------------------------------------------
// writeback_sequencer
//
// Writeback stage sitting directly behind the main ALU. It turns each executed
// instruction into write strobes for a single-write-port register file. A SWAP
// needs two register writes, so it is split over two consecutive cycles and
// upstream is held off for one cycle. An ADD/SUB overflow suppresses the write
// and instead raises a one-cycle pulse, a sticky flag and a saturating count.
//
// Parameters
//   ADDR_W  register address width
//   DATA_W  register data width (the packed ALU result is 2*DATA_W wide)
//   CNT_W   overflow event counter width
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   in_valid     upstream presents an instruction
//   in_ready     block can accept (decoded from state only)
//   in_alu_ctrl  ALU opcode: 000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND,
//                101/110/111 OR
//   in_result    packed result: low half primary, high half secondary (SWAP)
//   in_overflow  ALU overflow flag (only meaningful for ADD/SUB)
//   in_wen       instruction writes the register file
//   in_rd1       primary destination register
//   in_rd2       secondary destination register (SWAP only)
//   ovf_clear    clears ovf_sticky and ovf_count
//   wr_en        register-file write strobe (registered)
//   wr_addr      register-file write address (registered)
//   wr_data      register-file write data (registered)
//   ovf_pulse    one-cycle pulse per overflowed ADD/SUB (registered)
//   ovf_sticky   set by any overflow event, held until ovf_clear
//   ovf_count    saturating count of overflow events
// -----------------------------------------------------------------------------
module writeback_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_alu_ctrl,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic                  in_overflow,
    input  logic                  in_wen,
    input  logic [ADDR_W-1:0]     in_rd1,
    input  logic [ADDR_W-1:0]     in_rd2,
    input  logic                  ovf_clear,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  ovf_pulse,
    output logic                  ovf_sticky,
    output logic [CNT_W-1:0]      ovf_count
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SWAP = 3'b011;

    typedef enum logic {
        RUN   = 1'b0,
        SWAP2 = 1'b1
    } state_t;

    state_t              state_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                ovf_pulse_q;
    logic                ovf_sticky_q;
    logic                ovf_sticky_d;
    logic [CNT_W-1:0]    ovf_count_q;
    logic [CNT_W-1:0]    ovf_count_d;

    // Second half of a SWAP, parked until the SWAP2 cycle.
    logic [ADDR_W-1:0]   sec_addr_q;
    logic [DATA_W-1:0]   sec_data_q;

    logic                accept;
    logic                is_addsub;
    logic                is_swap;
    logic                ovf_event;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + CNT_W'(1);
    endfunction

    // in_ready depends on the state register alone so upstream never sees a
    // combinational path from its own valid/data back into ready.
    assign in_ready  = (state_q == RUN);
    assign accept    = in_valid && in_ready;
    assign is_addsub = (in_alu_ctrl == OP_ADD) || (in_alu_ctrl == OP_SUB);
    assign is_swap   = (in_alu_ctrl == OP_SWAP);
    assign ovf_event = accept && in_wen && is_addsub && in_overflow;

    // Overflow bookkeeping. An event in the same cycle as ovf_clear wins: the
    // clear wipes the old history and the new event is counted from zero.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (ovf_event) begin
            ovf_sticky_d = 1'b1;
            ovf_count_d  = ovf_clear ? CNT_W'(1) : sat_inc(ovf_count_q);
        end else if (ovf_clear) begin
            ovf_sticky_d = 1'b0;
            ovf_count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            ovf_pulse_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
            sec_addr_q   <= '0;
            sec_data_q   <= '0;
        end else begin
            // Strobes default low so each write lasts exactly one cycle.
            wr_en_q      <= 1'b0;
            ovf_pulse_q  <= 1'b0;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;

            case (state_q)
                RUN: begin
                    if (accept && in_wen) begin
                        if (ovf_event) begin
                            ovf_pulse_q <= 1'b1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= in_rd1;
                            wr_data_q <= in_result[DATA_W-1:0];
                            if (is_swap) begin
                                sec_addr_q <= in_rd2;
                                sec_data_q <= in_result[2*DATA_W-1:DATA_W];
                                state_q    <= SWAP2;
                            end
                        end
                    end
                end
                SWAP2: begin
                    // rd1==rd2 still gets both writes; this later one lands last.
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= sec_addr_q;
                    wr_data_q <= sec_data_q;
                    state_q   <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign ovf_pulse  = ovf_pulse_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
module tb_writeback_sequencer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_alu_ctrl;
    logic [2*DATA_W-1:0] in_result;
    logic                in_overflow;
    logic                in_wen;
    logic [ADDR_W-1:0]   in_rd1;
    logic [ADDR_W-1:0]   in_rd2;
    logic                ovf_clear;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                ovf_pulse;
    logic                ovf_sticky;
    logic [CNT_W-1:0]    ovf_count;

    int checks = 0;
    int errors = 0;

    writeback_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_ctrl(in_alu_ctrl),
        .in_result  (in_result),
        .in_overflow(in_overflow),
        .in_wen     (in_wen),
        .in_rd1     (in_rd1),
        .in_rd2     (in_rd2),
        .ovf_clear  (ovf_clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ovf_pulse  (ovf_pulse),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic ovf, input logic wen,
                         input logic [3:0] rd1, input logic [3:0] rd2);
        in_valid    = v;
        in_alu_ctrl = op;
        in_result   = res;
        in_overflow = ovf;
        in_wen      = wen;
        in_rd1      = rd1;
        in_rd2      = rd2;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [15:0] d);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        if (en) begin
            chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
            chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        end
    endtask

    initial begin
        reset     = 1'b1;
        ovf_clear = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        step();

        // Reset values
        chk("rst.in_ready",   32'(in_ready),   32'd1);
        chk("rst.wr_en",      32'(wr_en),      32'd0);
        chk("rst.wr_addr",    32'(wr_addr),    32'd0);
        chk("rst.wr_data",    32'(wr_data),    32'd0);
        chk("rst.ovf_pulse",  32'(ovf_pulse),  32'd0);
        chk("rst.ovf_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst.ovf_count",  32'(ovf_count),  32'd0);
        reset = 1'b0;

        // ADD without overflow
        drive(1'b1, 3'b000, 32'h0000_1234, 1'b0, 1'b1, 4'd3, 4'd0);
        step();
        chk_wr("add", 1'b1, 4'd3, 16'h1234);
        chk("add.ovf_pulse", 32'(ovf_pulse), 32'd0);
        chk("add.in_ready",  32'(in_ready),  32'd1);

        // SWAP followed by an OR held behind it
        drive(1'b1, 3'b011, 32'hAAAA_5555, 1'b0, 1'b1, 4'd2, 4'd7);
        step();
        chk_wr("swap1", 1'b1, 4'd2, 16'h5555);
        chk("swap1.in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 3'b101, 32'h0000_00FF, 1'b0, 1'b1, 4'd1, 4'd0);
        step();
        chk_wr("swap2", 1'b1, 4'd7, 16'hAAAA);
        chk("swap2.in_ready", 32'(in_ready), 32'd1);
        step();
        chk_wr("or", 1'b1, 4'd1, 16'h00FF);
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk_wr("idle", 1'b0, 4'd0, 16'h0);

        // SWAP with rd1==rd2: both writes, upper half last
        drive(1'b1, 3'b011, 32'hBBBB_CCCC, 1'b0, 1'b1, 4'd8, 4'd8);
        step();
        chk_wr("swapeq1", 1'b1, 4'd8, 16'hCCCC);
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk_wr("swapeq2", 1'b1, 4'd8, 16'hBBBB);
        step();
        chk_wr("swapeq3", 1'b0, 4'd0, 16'h0);

        // Overflow on ADD with in_wen=0: nothing happens
        drive(1'b1, 3'b000, 32'h0000_1111, 1'b1, 1'b0, 4'd4, 4'd0);
        step();
        chk_wr("nowen", 1'b0, 4'd0, 16'h0);
        chk("nowen.ovf_pulse", 32'(ovf_pulse), 32'd0);
        chk("nowen.ovf_count", 32'(ovf_count), 32'd0);

        // SUB overflow
        drive(1'b1, 3'b001, 32'h0000_2222, 1'b1, 1'b1, 4'd4, 4'd0);
        step();
        chk_wr("subovf", 1'b0, 4'd0, 16'h0);
        chk("subovf.ovf_pulse",  32'(ovf_pulse),  32'd1);
        chk("subovf.ovf_sticky", 32'(ovf_sticky), 32'd1);
        chk("subovf.ovf_count",  32'(ovf_count),  32'd1);

        // MOVE with overflow flag: written normally
        drive(1'b1, 3'b010, 32'h0000_BEEF, 1'b1, 1'b1, 4'd5, 4'd0);
        step();
        chk_wr("move", 1'b1, 4'd5, 16'hBEEF);
        chk("move.ovf_pulse", 32'(ovf_pulse), 32'd0);
        chk("move.ovf_count", 32'(ovf_count), 32'd1);

        // Clear, then 256 overflowed ADDs saturate at 0xFF
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("clr0.ovf_count",  32'(ovf_count),  32'd0);
        chk("clr0.ovf_sticky", 32'(ovf_sticky), 32'd0);
        drive(1'b1, 3'b000, 32'h0000_7FFF, 1'b1, 1'b1, 4'd6, 4'd0);
        for (int i = 0; i < 256; i++) begin
            step();
        end
        chk("sat.ovf_count", 32'(ovf_count), 32'hFF);
        chk("sat.wr_en",     32'(wr_en),     32'd0);

        // Clear and overflow together: event wins
        ovf_clear = 1'b1;
        step();
        chk("clrovf.ovf_count",  32'(ovf_count),  32'd1);
        chk("clrovf.ovf_sticky", 32'(ovf_sticky), 32'd1);
        chk("clrovf.ovf_pulse",  32'(ovf_pulse),  32'd1);

        // Clear alone
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        ovf_clear = 1'b0;
        chk("clr.ovf_count",  32'(ovf_count),  32'd0);
        chk("clr.ovf_sticky", 32'(ovf_sticky), 32'd0);
        chk("clr.ovf_pulse",  32'(ovf_pulse),  32'd0);

        // Reset mid-SWAP, asserted asynchronously in the SWAP2 cycle
        drive(1'b1, 3'b011, 32'h1234_5678, 1'b0, 1'b1, 4'd6, 4'd9);
        step();
        chk_wr("rswap1", 1'b1, 4'd6, 16'h5678);
        chk("rswap1.in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.wr_en",    32'(wr_en),    32'd0);
        chk("arst.wr_addr",  32'(wr_addr),  32'd0);
        chk("arst.wr_data",  32'(wr_data),  32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("rswap2.wr_en",    32'(wr_en),    32'd0);
        chk("rswap2.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back non-SWAP writes after reset: no bubbles
        drive(1'b1, 3'b100, 32'h0000_0F0F, 1'b0, 1'b1, 4'd10, 4'd0);
        step();
        chk_wr("and", 1'b1, 4'd10, 16'h0F0F);
        drive(1'b1, 3'b111, 32'hFFFF_00F0, 1'b0, 1'b1, 4'd11, 4'd0);
        step();
        chk_wr("or2", 1'b1, 4'd11, 16'h00F0);
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk_wr("end", 1'b0, 4'd0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_sequencer.md
# writeback_sequencer

- Writeback-stage block directly downstream of the main ALU.
- Consumes each executed instruction's 32-bit packed ALU result, its overflow flag and its ALU opcode, and turns it into register-file write strobes for the single-write-port register file.
- A SWAP produces two register writes, so the block issues them on consecutive cycles and stalls upstream for one cycle.
- ADD/SUB overflow is converted into a suppressed write plus a sticky exception flag and a saturating event counter.

## Interface
Parameters:
- ADDR_W, 4, register address width
- DATA_W, 16, register data width; packed result is 2*DATA_W
- CNT_W, 8, overflow event counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  block accepts when in_valid && in_ready
- in_alu_ctrl  input  3  ALU opcode: 000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND, 101/110/111 OR
- in_result  input  2*DATA_W  packed ALU result: [DATA_W-1:0] primary, [2*DATA_W-1:DATA_W] secondary (SWAP only)
- in_overflow  input  1  ALU overflow flag
- in_wen  input  1  instruction writes the register file
- in_rd1  input  ADDR_W  primary destination (Op1 register)
- in_rd2  input  ADDR_W  secondary destination (Op2 register; SWAP only)
- ovf_clear  input  1  clears ovf_sticky and ovf_count
- wr_en  output  1  register-file write strobe
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- ovf_pulse  output  1  one-cycle pulse per overflowed ADD/SUB
- ovf_sticky  output  1  set by any overflow event, held until ovf_clear
- ovf_count  output  CNT_W  saturating count of overflow events

## Operation
States:
- RUN: in_ready=1.
- SWAP2: in_ready=0; holds the latched secondary half and rd2.

Accepted instruction in RUN:
- in_wen=0: no write, no overflow action, stay RUN.
- ADD/SUB with in_overflow=1: no write; ovf_pulse=1 next cycle; ovf_sticky set; ovf_count increments, saturating at all-ones.
- in_overflow is ignored for every opcode other than 000/001.
- Non-SWAP otherwise: one write, wr_addr=in_rd1, wr_data=in_result[DATA_W-1:0]. Upper half ignored.
- SWAP (011) with in_wen=1: first write is rd1 <= in_result[DATA_W-1:0] (old Op2); latch the upper half and rd2; go SWAP2.

In SWAP2:
- Second write is rd2 <= latched in_result[2*DATA_W-1:DATA_W] (old Op1).
- Return to RUN.
- Inputs are ignored because in_ready=0.

Boundary cases:
- rd1==rd2 on SWAP: both writes are still issued; the register ends with the upper half.
- No accept (in_valid=0 or in_ready=0): wr_en=0, ovf_pulse=0.
- ovf_clear and an overflow event in the same cycle: the event wins, giving ovf_sticky=1 and ovf_count=1.
- reset mid-SWAP: the pending second write is dropped.

Reset values: state RUN, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, ovf_pulse=0, ovf_sticky=0, ovf_count=0.

## Timing
- All outputs except in_ready are registered. in_ready is decoded from the state register only, with no combinational path from inputs.
- Latency: an instruction accepted at edge N drives wr_en, wr_addr, wr_data and ovf_pulse in cycle N+1.
- SWAP sequence:
  - Accept at edge N.
  - First write in cycle N+1; in_ready=0 in N+1.
  - Second write in cycle N+2; in_ready=1 again in N+2.
  - The next accept occurs at the N+2 edge at the earliest, so its write appears in N+3.
- Throughput: 1 instruction/cycle for non-SWAP, 2 cycles per SWAP.
- wr_en is never high for more cycles than the required writes. No bubbles between back-to-back non-SWAP writes.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs immediately at their reset values; in_ready=1.
- ADD, no overflow: ctrl=000, result=0x0000_1234, rd1=3, wen=1 -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234; ovf_pulse=0.
- SWAP: ctrl=011, result=0xAAAA_5555, rd1=2, rd2=7, then a valid OR (rd1=1, result=0x00FF) held behind it -> cycle+1 writes r2=0x5555 with in_ready=0; cycle+2 writes r7=0xAAAA; OR write r1=0x00FF in cycle+3.
- Overflow: SUB with in_overflow=1, rd1=4 -> no write; ovf_pulse one cycle; ovf_sticky=1; ovf_count=1. Then MOVE with in_overflow=1 -> written normally, count unchanged.
- Counter saturation and clear: 256 overflowed ADDs -> ovf_count=0xFF. Then ovf_clear in the same cycle as another overflow -> ovf_count=1, ovf_sticky=1. Then ovf_clear alone -> both 0.
- Reset mid-SWAP: assert reset in the SWAP2 cycle -> no second write, state RUN, in_ready=1 after reset release.
